fetch_stage: RTL and testbench

//   Instruction-fetch stage: owns the program counter and the IF/ID pipeline register.

---
 rtl/fetch_stage_pkg.sv | 25 ++
 rtl/fetch_stage_if_id_reg.sv | 33 +++
 rtl/fetch_stage.sv | 79 +++++++
 tb/tb_fetch_stage.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared constants and types for the instruction-fetch stage: chip-enable levels,
// stall-vector bit positions, default reset PC and the PC source selector.
package fetch_stage_pkg;

  localparam logic        CHIP_ENABLE      = 1'b1;
  localparam logic        CHIP_DISABLE     = 1'b0;
  localparam int          INST_ADDR_W      = 32;
  localparam int          INST_DATA_W      = 32;
  localparam int          STALL_W          = 6;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Stall vector bits consumed by the fetch stage; the upper bits belong to later stages.
  localparam int STALL_HOLD_PC = 0;
  localparam int STALL_HOLD_IF = 1;
  localparam int STALL_ID      = 2;

  typedef enum logic [2:0] {
    PC_RESET,
    PC_FLUSH,
    PC_HOLD,
    PC_BRANCH,
    PC_SEQ
  } pc_sel_e;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: clears on reset/flush, inserts a bubble when IF holds while
// ID advances, loads the fetched {pc, inst} when IF advances, otherwise holds.
module if_id_reg #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              hold,
  input  logic              id_stall,
  input  logic [ADDR_W-1:0] if_pc,
  input  logic [DATA_W-1:0] if_inst,
  output logic [ADDR_W-1:0] id_pc,
  output logic [DATA_W-1:0] id_inst
);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst || flush) begin
      id_pc   <= '0;
      id_inst <= '0;
    end else if (hold && !id_stall) begin
      // IF is frozen but ID moves on: feed it a NOP so the held word is not issued twice.
      id_pc   <= '0;
      id_inst <= '0;
    end else if (!hold) begin
      id_pc   <= if_pc;
      id_inst <= if_inst;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: program counter with reset/flush/stall/branch priority,
// ROM chip enable, and the IF/ID register feeding decode (MIPS delayed branches).
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int                ADDR_W   = INST_ADDR_W,
  parameter int                DATA_W   = INST_DATA_W,
  parameter int                STALL_W  = fetch_stage_pkg::STALL_W,
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic [ADDR_W-1:0]  new_pc,
  input  logic               branch_flag,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic               ce,
  output logic [ADDR_W-1:0]  pc,
  input  logic [DATA_W-1:0]  rom_inst,
  output logic [ADDR_W-1:0]  id_pc,
  output logic [DATA_W-1:0]  id_inst
);

  pc_sel_e           pc_sel;
  logic [ADDR_W-1:0] pc_next;
  logic [DATA_W-1:0] fetch_inst;
  logic              unused_bits;

  // Low address bits are forced to zero on load, and later-stage stall bits are not ours.
  assign unused_bits = ^{stall[STALL_W-1:STALL_ID+1], new_pc[1:0], branch_target[1:0]};

  always_comb begin
    // NOTE: defaults first so no path leaves a combinational output unassigned (no latch).
    pc_sel  = PC_SEQ;
    pc_next = pc + ADDR_W'(4);
    if (ce == CHIP_DISABLE)     pc_sel = PC_RESET;
    else if (flush)             pc_sel = PC_FLUSH;
    else if (stall[STALL_HOLD_PC]) pc_sel = PC_HOLD;
    else if (branch_flag)       pc_sel = PC_BRANCH;

    case (pc_sel)
      PC_RESET:  pc_next = RESET_PC;
      PC_FLUSH:  pc_next = {new_pc[ADDR_W-1:2], 2'b00};
      PC_HOLD:   pc_next = pc;
      PC_BRANCH: pc_next = {branch_target[ADDR_W-1:2], 2'b00};
      default:   pc_next = pc + ADDR_W'(4);
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ce <= CHIP_DISABLE;
      pc <= RESET_PC;
    end else begin
      ce <= CHIP_ENABLE;
      pc <= pc_next;
    end
  end

  // The ROM output is meaningless while disabled; pass a NOP instead.
  assign fetch_inst = (ce == CHIP_ENABLE) ? rom_inst : '0;

  if_id_reg #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_if_id_reg (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .hold     (stall[STALL_HOLD_IF]),
    .id_stall (stall[STALL_ID]),
    .if_pc    (pc),
    .if_inst  (fetch_inst),
    .id_pc    (id_pc),
    .id_inst  (id_inst)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed scenarios then random traffic, checked
// against a behavioural model of the PC and IF/ID rules with a combinational ROM.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic        ce;
  logic [31:0] pc;
  logic [31:0] rom_inst;
  logic [31:0] id_pc;
  logic [31:0] id_inst;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        ce;
    logic [31:0] pc;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state
  logic        m_ce;
  logic [31:0] m_pc;
  logic [31:0] m_id_pc;
  logic [31:0] m_id_inst;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return {a[31:2], 2'b01} ^ 32'h9E37_79B9;
  endfunction

  assign rom_inst = rom(pc);

  fetch_stage dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .flush         (flush),
    .new_pc        (new_pc),
    .branch_flag   (branch_flag),
    .branch_target (branch_target),
    .ce            (ce),
    .pc            (pc),
    .rom_inst      (rom_inst),
    .id_pc         (id_pc),
    .id_inst       (id_inst)
  );

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Apply the fetch rules to the current inputs and model state for one clock edge.
  task automatic model_edge();
    logic        n_ce;
    logic [31:0] n_pc, n_id_pc, n_id_inst;
    if (rst) begin
      n_ce = 1'b0; n_pc = 32'h0; n_id_pc = 32'h0; n_id_inst = 32'h0;
    end else begin
      n_ce = 1'b1;
      if (!m_ce)            n_pc = 32'h0;
      else if (flush)       n_pc = new_pc & ~32'd3;
      else if (stall[0])    n_pc = m_pc;
      else if (branch_flag) n_pc = branch_target & ~32'd3;
      else                  n_pc = m_pc + 32'd4;
      if (flush || (stall[1] && !stall[2])) begin
        n_id_pc = 32'h0; n_id_inst = 32'h0;
      end else if (!stall[1]) begin
        n_id_pc = m_pc; n_id_inst = m_ce ? rom(m_pc) : 32'h0;
      end else begin
        n_id_pc = m_id_pc; n_id_inst = m_id_inst;
      end
    end
    m_ce = n_ce; m_pc = n_pc; m_id_pc = n_id_pc; m_id_inst = n_id_inst;
  endtask

  task automatic step(input logic r, input logic [5:0] st, input logic fl,
                      input logic [31:0] np, input logic br, input logic [31:0] bt);
    rst = r; stall = st; flush = fl; new_pc = np; branch_flag = br; branch_target = bt;
    model_edge();
    exp_q.push_back('{ce: m_ce, pc: m_pc, id_pc: m_id_pc, id_inst: m_id_inst});
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 6'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  // Monitor: every edge the registered outputs are compared with the oldest expectation.
  always @(posedge clk) begin
    #2;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("ce", {31'b0, ce}, {31'b0, e.ce});
      check("pc", pc, e.pc);
      check("id_pc", id_pc, e.id_pc);
      check("id_inst", id_inst, e.id_inst);
    end
  end

  initial begin
    rst = 1'b1; stall = '0; flush = 1'b0; new_pc = '0; branch_flag = 1'b0; branch_target = '0;
    m_ce = 1'b0; m_pc = '0; m_id_pc = '0; m_id_inst = '0;

    // T1: reset then sequential fetch from RESET_PC
    repeat (3) step(1'b1, 6'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    repeat (5) idle();

    // T2: hold with ID stalled, then bubble, then release
    repeat (2) step(1'b0, 6'b000111, 1'b0, 32'h0, 1'b0, 32'h0);
    step(1'b0, 6'b000011, 1'b0, 32'h0, 1'b0, 32'h0);
    repeat (2) idle();

    // T3: delay-slot branch at pc=0x20, then unaligned target
    for (int i = 0; i < 64 && m_pc != 32'h20; i++) idle();
    step(1'b0, 6'b0, 1'b0, 32'h0, 1'b1, 32'h100);
    idle();
    step(1'b0, 6'b0, 1'b0, 32'h0, 1'b1, 32'h103);
    repeat (2) idle();

    // T4: flush beats branch and stall
    step(1'b0, 6'b000011, 1'b1, 32'h180, 1'b1, 32'h200);
    repeat (2) idle();

    // T5: wrap past the top of the address space
    step(1'b0, 6'b0, 1'b1, 32'hFFFF_FFF8, 1'b0, 32'h0);
    repeat (3) idle();

    // T6: reset mid stall/branch
    step(1'b1, 6'b000011, 1'b0, 32'h0, 1'b1, 32'h300);
    repeat (3) idle();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic        r, fl, br;
      logic [5:0]  st;
      r  = ($urandom_range(0, 63) == 0);
      fl = ($urandom_range(0, 15) == 0);
      br = ($urandom_range(0, 5) == 0);
      st = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'b0;
      step(r, st, fl, $urandom, br, $urandom);
    end

    #5;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
